// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------
// pwm_pkg : shared register map, mode encoding and counter helpers
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

package pwm_pkg;

   typedef enum logic {
      MODE_EDGE   = 1'b0,
      MODE_CENTRE = 1'b1
   } pwm_mode_e;

   localparam int DUTY_BASE = 0;

   // Control registers sit directly above the duty block, so they move with NUM_CH.
   function automatic int REG_MASK(input int num_ch);
      return DUTY_BASE + num_ch;
   endfunction

   function automatic int REG_PRESC(input int num_ch);
      return DUTY_BASE + num_ch + 1;
   endfunction

   function automatic int REG_MODE(input int num_ch);
      return DUTY_BASE + num_ch + 2;
   endfunction

   function automatic int MAXC(input int cnt_w);
      return (1 << cnt_w) - 2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_multi_channel_if.sv
// ---------------------------------------------------------------------
// pwm_multi_channel_if : register write port from the SPI register bank
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

interface pwm_multi_channel_if;

   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;

   modport master (
      output wr_en,
      output wr_addr,
      output wr_data
   );

   modport slave (
      input wr_en,
      input wr_addr,
      input wr_data
   );

endinterface

`default_nettype wire

// File: rtl/pwm_timebase.sv
// ---------------------------------------------------------------------
// pwm_timebase : prescaler, edge/centre up-down counter, boundary detect
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int PRESC_W = 12
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   input  wire logic               ena,
   input  wire logic [PRESC_W-1:0] presc,
   input  pwm_mode_e               mode,
   input  wire logic               presc_clr,
   input  wire logic               restart,
   output logic      [CNT_W-1:0]   cnt,
   output logic                    tick,
   output logic                    boundary
);

   localparam logic [CNT_W-1:0] C_MAXC = CNT_W'(MAXC(CNT_W));

   logic [PRESC_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dir_down_q, dir_down_d;

   always_comb begin
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      dir_down_d = dir_down_q;
      boundary   = 1'b0;
      tick       = rst_n & ena & (pc_q == presc);

      if (ena) begin
         pc_d = tick ? '0 : pc_q + 1'b1;
      end

      if (tick) begin
         if (mode == MODE_EDGE) begin
            cnt_d      = (cnt_q >= C_MAXC) ? '0 : cnt_q + 1'b1;
            dir_down_d = 1'b0;
         end else if (!dir_down_q) begin
            if (cnt_q >= C_MAXC) begin
               cnt_d      = cnt_q - 1'b1;
               dir_down_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            // Turn around on reaching zero so the next tick climbs again.
            if (cnt_q <= 1) begin
               cnt_d      = '0;
               dir_down_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         boundary = (cnt_d == '0);
      end

      if (presc_clr) begin
         pc_d = '0;
      end

      // A mode change restarts the period silently, without a boundary pulse.
      if (restart) begin
         pc_d       = '0;
         cnt_d      = '0;
         dir_down_d = 1'b0;
         boundary   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= '0;
         cnt_q      <= '0;
         dir_down_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         dir_down_q <= dir_down_d;
      end
   end

   assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pwm_multi_channel.sv
// ---------------------------------------------------------------------
// pwm_multi_channel : N-channel PWM with double-buffered duty registers
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module pwm_multi_channel
   import pwm_pkg::*;
#(
   parameter int NUM_CH  = 8,
   parameter int CNT_W   = 8,
   parameter int PRESC_W = 12
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              ena,
   pwm_multi_channel_if.slave     wr,
   output logic      [NUM_CH-1:0] pwm_out,
   output logic                   period_tick,
   output logic                   upd_pending
);

   localparam logic [7:0] C_ADDR_MASK  = 8'(REG_MASK(NUM_CH));
   localparam logic [7:0] C_ADDR_PRESC = 8'(REG_PRESC(NUM_CH));
   localparam logic [7:0] C_ADDR_MODE  = 8'(REG_MODE(NUM_CH));

   logic [CNT_W-1:0]   shadow_q   [NUM_CH];
   logic [CNT_W-1:0]   shadow_d   [NUM_CH];
   logic [CNT_W-1:0]   duty_act_q [NUM_CH];
   logic [CNT_W-1:0]   duty_act_d [NUM_CH];
   logic [NUM_CH-1:0]  ch_en_q, ch_en_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   pwm_mode_e          mode_q, mode_d;
   logic               upd_pending_q, upd_pending_d;
   logic [NUM_CH-1:0]  pwm_out_q, pwm_out_d;

   logic [NUM_CH-1:0]  w_duty_sel;
   logic               w_duty_wr;
   logic               w_mask_wr;
   logic               w_presc_wr;
   logic               w_mode_wr;
   logic [CNT_W-1:0]   w_cnt;
   logic               w_tick;
   logic               w_boundary;
   logic               w_unused;

   always_comb begin
      w_duty_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_duty_sel[i] = wr.wr_en && (wr.wr_addr == 8'(DUTY_BASE + i));
      end
   end

   assign w_duty_wr  = |w_duty_sel;
   assign w_mask_wr  = wr.wr_en && (wr.wr_addr == C_ADDR_MASK);
   assign w_presc_wr = wr.wr_en && (wr.wr_addr == C_ADDR_PRESC);
   assign w_mode_wr  = wr.wr_en && (wr.wr_addr == C_ADDR_MODE);
   assign w_unused   = &{1'b0, wr.wr_data, w_tick};

   pwm_timebase #(
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W)
   ) u_timebase (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .presc     (presc_q),
      .mode      (mode_q),
      .presc_clr (w_presc_wr),
      .restart   (w_mode_wr),
      .cnt       (w_cnt),
      .tick      (w_tick),
      .boundary  (w_boundary)
   );

   always_comb begin
      shadow_d      = shadow_q;
      duty_act_d    = duty_act_q;
      ch_en_d       = ch_en_q;
      presc_d       = presc_q;
      mode_d        = mode_q;
      upd_pending_d = upd_pending_q;
      pwm_out_d     = '0;

      // Active duties always take the pre-write shadow, so a write landing
      // on a boundary waits a full period and keeps the pending flag set.
      if (w_boundary || w_mode_wr) begin
         duty_act_d    = shadow_q;
         upd_pending_d = 1'b0;
      end

      for (int i = 0; i < NUM_CH; i++) begin
         if (w_duty_sel[i]) begin
            shadow_d[i] = wr.wr_data[CNT_W-1:0];
         end
      end
      if (w_duty_wr) begin
         upd_pending_d = 1'b1;
      end
      if (w_mask_wr) begin
         ch_en_d = wr.wr_data[NUM_CH-1:0];
      end
      if (w_presc_wr) begin
         presc_d = wr.wr_data[PRESC_W-1:0];
      end
      if (w_mode_wr) begin
         mode_d = pwm_mode_e'(wr.wr_data[0]);
      end

      for (int i = 0; i < NUM_CH; i++) begin
         pwm_out_d[i] = ena & ch_en_q[i] & (w_cnt < duty_act_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_q      <= '{default: '0};
         duty_act_q    <= '{default: '0};
         ch_en_q       <= '0;
         presc_q       <= '0;
         mode_q        <= MODE_EDGE;
         upd_pending_q <= 1'b0;
         pwm_out_q     <= '0;
      end else begin
         shadow_q      <= shadow_d;
         duty_act_q    <= duty_act_d;
         ch_en_q       <= ch_en_d;
         presc_q       <= presc_d;
         mode_q        <= mode_d;
         upd_pending_q <= upd_pending_d;
         pwm_out_q     <= pwm_out_d;
      end
   end

   assign pwm_out     = pwm_out_q;
   assign period_tick = w_boundary;
   assign upd_pending = upd_pending_q;

endmodule

`default_nettype wire

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
- N-channel PWM generator, successor to the single-channel onboarding PWM peripheral.
- Configured through a simple register write port driven by the SPI register bank. Outputs feed uo_out/uio_out and the test bit.
- Adds parametrised channel count and resolution, a clock prescaler, double-buffered duty updates, and a centre-aligned mode.

Parameters:
- NUM_CH, 8, number of PWM channels (1..16).
- CNT_W, 8, duty/counter resolution in bits (4..12).
- PRESC_W, 12, prescaler width in bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  design enable; low freezes counters and forces outputs low
- wr_en  in  1  single-cycle register write strobe
- wr_addr  in  8  register address
- wr_data  in  16  write data, LSB-aligned fields
- pwm_out  out  NUM_CH  registered PWM outputs
- period_tick  out  1  one-cycle pulse at each period boundary
- upd_pending  out  1  a duty write is waiting for the next boundary

Behaviour:
- Register map:
  - addr 0..NUM_CH-1: duty shadow[i] = wr_data[CNT_W-1:0]
  - NUM_CH: ch_en mask = wr_data[NUM_CH-1:0]
  - NUM_CH+1: presc = wr_data[PRESC_W-1:0]
  - NUM_CH+2: mode = wr_data[0] (0 = edge, 1 = centre)
  - Other addresses are ignored.
- Reset (rst_n low at a clk edge):
  - All counters, shadow, active duty, mask, presc and mode are cleared to 0.
  - pwm_out = 0, period_tick = 0, upd_pending = 0.
  - Reset mid-period aborts the period immediately; there is no graceful finish.
- Prescaler:
  - Counter runs 0..presc, issuing a tick when it equals presc. presc = 0 gives a tick every clock.
  - A write to presc clears the prescaler counter; the new value applies from the next cycle.
- Edge mode:
  - cnt runs 0..MAXC on ticks, with MAXC = 2^CNT_W-2, then wraps to 0. Period = (2^CNT_W-1)*(presc+1) clocks.
- Centre mode:
  - cnt follows 0,1..MAXC,MAXC-1..1, then repeats, with direction held in a flag.
  - Period = 2*MAXC*(presc+1) clocks.
- Boundary: the tick on which cnt becomes 0. On that cycle:
  - period_tick pulses.
  - All active duties load from shadow.
  - upd_pending clears.
- Output: pwm_out[i] <= ena & ch_en[i] & (cnt < duty_act[i]), one clock after cnt.
  - duty 0 gives a constant low; duty 2^CNT_W-1 gives a constant high in both modes.
- Duty write:
  - Updates shadow only and sets upd_pending; pwm_out is unaffected until the next boundary.
  - Duty write on a boundary cycle: active loads the pre-write shadow, the new value stays in shadow, and upd_pending remains set.
- Mask write takes effect on the next cycle. This is not double-buffered.
- Mode write:
  - Clears cnt and the prescaler, sets direction up, loads active from shadow, and clears upd_pending.
  - No period_tick is issued.
- ena low:
  - cnt and prescaler hold; pwm_out forced 0; period_tick is 0.
  - Register writes are still accepted.
  - On ena rise, counting resumes from the held values.

Decomposition:
- Package pwm_pkg holds:
  - register address offsets (DUTY_BASE, REG_MASK = NUM_CH, REG_PRESC, REG_MODE)
  - mode enum (MODE_EDGE, MODE_CENTRE)
  - helper MAXC(CNT_W)
- One sub-module, pwm_timebase: prescaler, up/down counter, boundary detection. It outputs cnt, tick and boundary.
- The top holds the register file, the shadow/active duty arrays and the per-channel comparators.

Test Plan:
All scenarios use NUM_CH=8 and CNT_W=8.
- Edge, basic duty:
  - Stimulus: presc=0, duty0=64, mask=0x01.
  - Required: pwm_out[0] high 64 clocks, low 191, period 255; period_tick every 255 clocks; other outputs 0.
- Double buffer:
  - Stimulus: duty0=64 running; write duty0=200 at cnt=30.
  - Required: the current period still has 64 high; upd_pending goes 1, then 0 at the boundary; the next period has 200 high.
- Extremes:
  - Stimulus: duty1=0, duty2=255, mask=0x06.
  - Required: pwm_out[1] constant 0, pwm_out[2] constant 1 across 3 periods.
- Prescaler:
  - Stimulus: presc=3, duty0=128.
  - Required: period 1020 clocks, high 512 clocks.
- Centre mode:
  - Stimulus: mode=1, presc=0, duty0=100.
  - Required: period 508 clocks, 199 high contiguous around cnt=0, period_tick every 508 clocks.
- Gating and reset:
  - Stimulus: ena=0 mid-period.
  - Required: outputs 0 and cnt frozen; restoring ena resumes from the frozen cnt.
  - Stimulus: assert rst_n low for one clock mid-period.
  - Required: all outputs 0 and all registers 0 on the next cycle.
